// File: rtl/md5_msg_padder.sv
// md5_msg_padder: packs a byte stream into 512-bit MD5 blocks, appends the
// 0x80 marker, zero fill and 64-bit little-endian bit length, and hands each
// block to the hash core over a valid/ready handshake.
module md5_msg_padder #(
  parameter int LEN_W  = 64,  // appended bit-length field width (fixed by MD5)
  parameter int BCNT_W = 61   // message byte counter width
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  input  logic        empty_i,
  output logic        byte_ready_o,
  output logic [31:0] M_o [0:15],
  output logic        blk_valid_o,
  input  logic        blk_ready_i,
  output logic        blk_last_o,
  output logic        busy_o
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] PAD  = 2'd1;
  localparam logic [1:0] LEN  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]        state_q;
  logic [5:0]        idx_q;
  logic [BCNT_W-1:0] byte_cnt_q;
  logic              need_len_q;
  logic              pending_pad_q;
  logic              blk_valid_q;
  logic              blk_last_q;
  logic              busy_q;
  logic [7:0]        buf_q [0:63];

  logic [LEN_W-1:0]  bit_len;
  logic              xfer;
  logic              empty_ok;

  // Message length in bits, wrapping modulo 2^64 along with the byte counter.
  assign bit_len  = LEN_W'({byte_cnt_q, 3'b000});
  assign xfer     = byte_valid_i && byte_ready_o;
  assign empty_ok = empty_i && (idx_q == 6'd0) && (byte_cnt_q == '0);

  assign byte_ready_o = (state_q == FILL) && rst_i;
  assign blk_valid_o  = blk_valid_q;
  assign blk_last_o   = blk_last_q;
  assign busy_o       = busy_q;

  // Present the byte buffer as sixteen little-endian 32-bit words.
  always_comb begin
    for (int w = 0; w < 16; w++) begin
      M_o[w] = {buf_q[4*w+3], buf_q[4*w+2], buf_q[4*w+1], buf_q[4*w]};
    end
  end

  // Padder state machine: fill, pad, optional length-only block, output.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= FILL;
      idx_q         <= '0;
      byte_cnt_q    <= '0;
      need_len_q    <= 1'b0;
      pending_pad_q <= 1'b0;
      blk_valid_q   <= 1'b0;
      blk_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      // NOTE: the buffer is reset because zero fill relies on it being clear;
      // a reset mid-message must not leak stale bytes into the next block.
      for (int i = 0; i < 64; i++) buf_q[i] <= 8'h00;
    end else begin
      case (state_q)
        FILL: begin
          if (xfer) begin
            buf_q[idx_q] <= byte_i;
            idx_q        <= idx_q + 6'd1;
            byte_cnt_q   <= byte_cnt_q + 1'b1;
            busy_q       <= 1'b1;
            if (idx_q == 6'd63) begin
              state_q       <= OUT;
              blk_valid_q   <= 1'b1;
              blk_last_q    <= 1'b0;
              pending_pad_q <= byte_last_i;
            end else if (byte_last_i) begin
              state_q <= PAD;
            end
          end else if (empty_ok) begin
            state_q <= PAD;
            busy_q  <= 1'b1;
          end
        end

        PAD: begin
          buf_q[idx_q] <= 8'h80;
          state_q      <= OUT;
          blk_valid_q  <= 1'b1;
          if (idx_q <= 6'd55) begin
            for (int i = 0; i < 8; i++) buf_q[56+i] <= bit_len[8*i +: 8];
            blk_last_q <= 1'b1;
          end else begin
            blk_last_q <= 1'b0;
            need_len_q <= 1'b1;
          end
        end

        LEN: begin
          for (int i = 0; i < 8; i++) buf_q[56+i] <= bit_len[8*i +: 8];
          need_len_q  <= 1'b0;
          blk_last_q  <= 1'b1;
          blk_valid_q <= 1'b1;
          state_q     <= OUT;
        end

        OUT: begin
          if (blk_ready_i) begin
            for (int i = 0; i < 64; i++) buf_q[i] <= 8'h00;
            idx_q       <= '0;
            blk_valid_q <= 1'b0;
            if (pending_pad_q) begin
              state_q       <= PAD;
              pending_pad_q <= 1'b0;
            end else if (need_len_q) begin
              state_q <= LEN;
            end else if (blk_last_q) begin
              state_q    <= FILL;
              byte_cnt_q <= '0;
              busy_q     <= 1'b0;
              blk_last_q <= 1'b0;
            end else begin
              state_q <= FILL;
            end
          end
        end

        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// tb_md5_msg_padder: directed vectors with hand-computed MD5 padding blocks.
module tb_md5_msg_padder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_last_i;
  logic        empty_i;
  logic        byte_ready_o;
  logic [31:0] m [0:15];
  logic        blk_valid_o;
  logic        blk_ready_i;
  logic        blk_last_o;
  logic        busy_o;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_w [0:15];

  md5_msg_padder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_last_i  (byte_last_i),
    .empty_i      (empty_i),
    .byte_ready_o (byte_ready_o),
    .M_o          (m),
    .blk_valid_o  (blk_valid_o),
    .blk_ready_i  (blk_ready_i),
    .blk_last_o   (blk_last_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    while (!byte_ready_o && n < 200) begin
      step();
      n++;
    end
    if (!byte_ready_o) begin
      total++;
      $error("FAIL byte_ready_timeout: observed 0 expected 1");
    end
    byte_i       = b;
    byte_last_i  = last;
    byte_valid_i = 1'b1;
    step();
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
  endtask

  task automatic wait_blk(input string tag);
    int n = 0;
    while (!blk_valid_o && n < 200) begin
      step();
      n++;
    end
    if (!blk_valid_o) begin
      total++;
      $error("FAIL %s_timeout: observed blk_valid 0 expected 1", tag);
    end
  endtask

  task automatic handshake();
    blk_ready_i = 1'b1;
    step();
    blk_ready_i = 1'b0;
  endtask

  task automatic check_block(input string tag, input logic [31:0] e [0:15], input logic last);
    check({tag, "_valid"}, {31'd0, blk_valid_o}, 32'd1);
    check({tag, "_last"},  {31'd0, blk_last_o},  {31'd0, last});
    for (int w = 0; w < 16; w++) begin
      check($sformatf("%s_w%0d", tag, w), m[w], e[w]);
    end
  endtask

  task automatic clear_exp();
    for (int w = 0; w < 16; w++) exp_w[w] = 32'h0;
  endtask

  task automatic send_abc();
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
  endtask

  initial begin
    rst_i        = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    empty_i      = 1'b0;
    blk_ready_i  = 1'b0;

    // Reset state
    step();
    step();
    check("rst_valid", {31'd0, blk_valid_o},  32'd0);
    check("rst_last",  {31'd0, blk_last_o},   32'd0);
    check("rst_busy",  {31'd0, busy_o},       32'd0);
    check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("rst_m0",    m[0],                  32'h0);
    check("rst_m15",   m[15],                 32'h0);
    rst_i = 1'b1;
    step();
    check("idle_ready", {31'd0, byte_ready_o}, 32'd1);

    // "abc": valid two cycles after the last byte
    send_abc();
    check("abc_pad_valid", {31'd0, blk_valid_o}, 32'd0);
    check("abc_busy",      {31'd0, busy_o},      32'd1);
    step();
    clear_exp();
    exp_w[0]  = 32'h80636261;
    exp_w[14] = 32'h00000018;
    check_block("abc", exp_w, 1'b1);
    check("abc_out_ready", {31'd0, byte_ready_o}, 32'd0);
    handshake();
    check("abc_post_valid", {31'd0, blk_valid_o},  32'd0);
    check("abc_post_busy",  {31'd0, busy_o},       32'd0);
    check("abc_post_ready", {31'd0, byte_ready_o}, 32'd1);

    // Zero-length message
    empty_i = 1'b1;
    step();
    empty_i = 1'b0;
    check("empty_busy", {31'd0, busy_o}, 32'd1);
    wait_blk("empty");
    clear_exp();
    exp_w[0] = 32'h00000080;
    check_block("empty", exp_w, 1'b1);
    handshake();

    // 55 bytes: marker and length fit in one block
    for (int i = 0; i < 55; i++) send_byte(8'h41, i == 54);
    wait_blk("b55");
    clear_exp();
    for (int w = 0; w < 13; w++) exp_w[w] = 32'h41414141;
    exp_w[13] = 32'h80414141;
    exp_w[14] = 32'h000001B8;
    check_block("b55", exp_w, 1'b1);
    handshake();

    // 56 bytes: length spills into a second block
    for (int i = 0; i < 56; i++) send_byte(8'h41, i == 55);
    wait_blk("b56a");
    clear_exp();
    for (int w = 0; w < 14; w++) exp_w[w] = 32'h41414141;
    exp_w[14] = 32'h00000080;
    check_block("b56a", exp_w, 1'b0);
    handshake();
    wait_blk("b56b");
    clear_exp();
    exp_w[14] = 32'h000001C0;
    check_block("b56b", exp_w, 1'b1);
    handshake();

    // 64 bytes: full block, then padding-only block
    for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63);
    check("b64_latency", {31'd0, blk_valid_o}, 32'd1);
    clear_exp();
    for (int w = 0; w < 16; w++) begin
      exp_w[w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    end
    check_block("b64a", exp_w, 1'b0);
    handshake();
    wait_blk("b64b");
    clear_exp();
    exp_w[0]  = 32'h00000080;
    exp_w[14] = 32'h00000200;
    check_block("b64b", exp_w, 1'b1);
    handshake();
    check("b64_done_busy", {31'd0, busy_o}, 32'd0);

    // Stall, then reset mid-hold, then a clean "abc"
    send_abc();
    wait_blk("hold");
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("hold%0d_m0", c),    m[0],                  32'h80636261);
      check($sformatf("hold%0d_m14", c),   m[14],                 32'h00000018);
      check($sformatf("hold%0d_last", c),  {31'd0, blk_last_o},   32'd1);
      check($sformatf("hold%0d_ready", c), {31'd0, byte_ready_o}, 32'd0);
    end
    rst_i = 1'b0;
    step();
    check("midrst_valid", {31'd0, blk_valid_o},  32'd0);
    check("midrst_busy",  {31'd0, busy_o},       32'd0);
    check("midrst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("midrst_m0",    m[0],                  32'h0);
    rst_i = 1'b1;
    step();
    send_abc();
    wait_blk("abc2");
    clear_exp();
    exp_w[0]  = 32'h80636261;
    exp_w[14] = 32'h00000018;
    check_block("abc2", exp_w, 1'b1);
    handshake();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/md5_msg_padder.md
Name: md5_msg_padder

Overview:
- Producer side of the MD5 core's message-word interface.
- Accepts an arbitrary-length byte stream and packs it into 512-bit blocks of sixteen 32-bit little-endian words.
- Appends MD5 padding: byte 0x80, zero fill, and the 64-bit little-endian bit length.
- Hands each block to the hash core over a valid/ready handshake, flagging the final block of the message.

Parameters:
- LEN_W, 64, width of the appended bit-length field; fixed by MD5 and shown for documentation only.
- BCNT_W, 61, width of the internal message byte counter; bit length is {byte_cnt, 3'b000} mod 2^64.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active low.
- byte_i  in  8  message byte.
- byte_valid_i  in  1  byte_i valid.
- byte_last_i  in  1  qualifies byte_i as the final message byte.
- empty_i  in  1  one-cycle strobe: zero-length message; honoured only in FILL with idx==0 and byte_cnt==0.
- byte_ready_o  out  1  padder can accept a byte.
- M_o  out  32x16 (unpacked [0:15])  block words; byte k of block = M_o[k/4][8*(k%4)+7 : 8*(k%4)].
- blk_valid_o  out  1  M_o holds a complete block.
- blk_ready_i  in  1  hash core accepts the block.
- blk_last_o  out  1  current block is the final block of the message.
- busy_o  out  1  high from first accepted byte (or empty_i) until the last block handshake.

Behaviour:
- Reset (rst_i==0 at a rising edge): state=FILL, idx=0, byte_cnt=0, need_len=0, buffer all-zero; outputs blk_valid_o=0, blk_last_o=0, busy_o=0, M_o=0, byte_ready_o=0 in the reset cycle. Reset mid-operation aborts the message; no partial block is emitted.
- byte_ready_o = (state==FILL) && rst_i. A byte transfers when byte_valid_i && byte_ready_o.
- FILL:
  - A transfer writes byte_i to buffer[idx], then idx++ and byte_cnt++.
  - If idx was 63: go to OUT with blk_last_o=0. Remember pending_pad=byte_last_i so padding follows after the handshake.
  - Else if byte_last_i: go to PAD.
  - empty_i (idx==0, byte_cnt==0): go to PAD. If empty_i coincides with a byte transfer, the byte wins and empty_i is ignored.
- PAD (exactly one cycle):
  - Write 0x80 at idx.
  - If idx<=55: write bit length into bytes 56..63 (LSB first), then go to OUT with blk_last_o=1.
  - If idx>=56: go to OUT with blk_last_o=0 and set need_len=1.
- LEN (one cycle): write bit length into bytes 56..63 of the zeroed buffer; go to OUT with blk_last_o=1; clear need_len.
- OUT:
  - blk_valid_o=1; M_o and blk_last_o are held stable until blk_ready_i.
  - On the handshake: clear the buffer to zero and set idx=0.
  - Next state after the handshake:
    - pending_pad set: PAD, with idx=0 and pending_pad cleared.
    - Else need_len set: LEN.
    - Else blk_last_o was 1: FILL, with byte_cnt=0 and busy_o dropping next cycle.
    - Else: FILL.
- blk_valid_o is registered. M_o is driven from the buffer register.
- Latency: last byte accepted at cycle t → PAD at t+1 → blk_valid_o=1 at t+2. Full non-last block: blk_valid_o=1 the cycle after the 64th byte. After a handshake with more data expected, byte_ready_o is 1 the next cycle.
- A new message may begin immediately after the last-block handshake. There is no message overlap.
- byte_cnt wraps modulo 2^61; the length field wraps modulo 2^64 accordingly.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) → one block: M_o[0]=0x80636261, M_o[1..13]=0, M_o[14]=0x00000018, M_o[15]=0, blk_last_o=1, blk_valid_o two cycles after the last byte.
- empty_i strobe → one block: M_o[0]=0x00000080, all other words 0, blk_last_o=1.
- 55 bytes of 0x41 → one block: M_o[13]=0x80414141, M_o[14]=0x000001B8, blk_last_o=1.
- 56 bytes of 0x41 → block 1: M_o[14]=0x00000080, M_o[15]=0, blk_last_o=0. Block 2 (via LEN): M_o[0..13]=0, M_o[14]=0x000001C0, blk_last_o=1.
- 64 bytes 0x00..0x3F → block 1: M_o[0]=0x03020100, M_o[15]=0x3F3E3D3C, last=0. Block 2 (via PAD at idx 0): M_o[0]=0x00000080, M_o[14]=0x00000200, last=1.
- Hold blk_ready_i=0 for 5 cycles during "abc" → M_o/blk_last_o stable, byte_ready_o=0. Then assert rst_i=0 mid-hold → next cycle blk_valid_o=0, busy_o=0, and a fresh "abc" afterwards produces the first-scenario block.
